// File: rtl/cr_rbus_initiator.sv
// cr_rbus_initiator: single-outstanding command/response bridge onto the register ring
`ifndef N_RBUS_ADDR_BITS
`define N_RBUS_ADDR_BITS 16
`endif
`ifndef N_RBUS_DATA_BITS
`define N_RBUS_DATA_BITS 32
`endif

typedef struct packed {
  logic                         wr_strb;
  logic                         rd_strb;
  logic [`N_RBUS_ADDR_BITS-1:0] addr;
  logic [`N_RBUS_DATA_BITS-1:0] wr_data;
  logic [`N_RBUS_DATA_BITS-1:0] rd_data;
  logic                         ack;
  logic                         err_ack;
} rbus_ring_t;

module cr_rbus_initiator #(
  parameter int N_RBUS_ADDR_BITS = `N_RBUS_ADDR_BITS,
  parameter int N_RBUS_DATA_BITS = `N_RBUS_DATA_BITS,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_wr,
  input  logic [N_RBUS_ADDR_BITS-1:0] cmd_addr,
  input  logic [N_RBUS_DATA_BITS-1:0] cmd_wr_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [N_RBUS_DATA_BITS-1:0] rsp_rd_data,
  output logic [1:0]                  rsp_status,
  output rbus_ring_t                  rbus_ring_o,
  input  rbus_ring_t                  rbus_ring_i,
  output logic [15:0]                 stat_txn_cnt,
  output logic [15:0]                 stat_err_cnt,
  output logic [15:0]                 stat_tmo_cnt,
  output logic [15:0]                 stat_stale_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t                      state;
  logic                        wr_q;
  logic                        wr_strb;
  logic                        rd_strb;
  logic [N_RBUS_ADDR_BITS-1:0] addr_q;
  logic [N_RBUS_DATA_BITS-1:0] wr_data_q;
  logic [15:0]                 cnt;
  logic                        accept;
  logic                        in_wait;
  logic                        done_ok;
  logic                        done_err;
  logic                        done_tmo;
  logic                        stale;
  logic                        unused_ring;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v + 16'(v != 16'hFFFF);
  endfunction
  assign accept   = cmd_valid & cmd_ready;
  assign in_wait  = state == WAIT;
  assign done_err = in_wait & rbus_ring_i.err_ack;
  assign done_ok  = in_wait & rbus_ring_i.ack & ~rbus_ring_i.err_ack;
  assign done_tmo = in_wait & ~rbus_ring_i.ack & ~rbus_ring_i.err_ack & (cnt == TMO_LAST);
  assign stale    = ~in_wait & (rbus_ring_i.ack | rbus_ring_i.err_ack);
  assign unused_ring = ^{rbus_ring_i.wr_strb, rbus_ring_i.rd_strb, rbus_ring_i.addr, rbus_ring_i.wr_data};
  assign rbus_ring_o = '{wr_strb: wr_strb, rd_strb: rd_strb, addr: addr_q, wr_data: wr_data_q,
                         rd_data: '0, ack: 1'b0, err_ack: 1'b0};
  // transaction FSM: latch command, strobe the ring for one cycle, await ack/err/timeout, hold response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      wr_q        <= 1'b0;
      wr_strb     <= 1'b0;
      rd_strb     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_rd_data <= '0;
      rsp_status  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= ~accept;
          if (accept) begin
            wr_q      <= cmd_wr;
            addr_q    <= cmd_addr;
            wr_data_q <= cmd_wr_data;
            wr_strb   <= cmd_wr;
            rd_strb   <= ~cmd_wr;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wr_strb <= 1'b0;
          rd_strb <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (done_err | done_ok | done_tmo) begin
            rsp_valid   <= 1'b1;
            rsp_status  <= done_ok ? 2'd0 : done_err ? 2'd1 : 2'd2;
            rsp_rd_data <= (done_ok & ~wr_q) ? rbus_ring_i.rd_data : '0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_txn_cnt   <= '0;
      stat_err_cnt   <= '0;
      stat_tmo_cnt   <= '0;
      stat_stale_cnt <= '0;
    end else begin
      if (done_ok | done_err | done_tmo) stat_txn_cnt <= sat_inc(stat_txn_cnt);
      if (done_err) stat_err_cnt <= sat_inc(stat_err_cnt);
      if (done_tmo) stat_tmo_cnt <= sat_inc(stat_tmo_cnt);
      if (stale) stat_stale_cnt <= sat_inc(stat_stale_cnt);
    end
  end
endmodule

// File: tb/tb_cr_rbus_initiator.sv
// tb_cr_rbus_initiator: directed checks of the ring initiator with TIMEOUT_CYCLES=8
module tb_cr_rbus_initiator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd_data;
  logic [1:0]  rsp_status;
  rbus_ring_t  ring_o;
  rbus_ring_t  ring_i;
  logic [15:0] txn;
  logic [15:0] err;
  logic [15:0] tmo;
  logic [15:0] stl;
  int          tests = 0;
  int          fails = 0;

  cr_rbus_initiator #(.N_RBUS_ADDR_BITS(16), .N_RBUS_DATA_BITS(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd_data(rsp_rd_data), .rsp_status(rsp_status),
    .rbus_ring_o(ring_o), .rbus_ring_i(ring_i),
    .stat_txn_cnt(txn), .stat_err_cnt(err), .stat_tmo_cnt(tmo), .stat_stale_cnt(stl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wr_data = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_ack(input logic a, input logic e, input logic [31:0] d);
    ring_i.ack = a; ring_i.err_ack = e; ring_i.rd_data = d;
    step();
    ring_i.ack = 1'b0; ring_i.err_ack = 1'b0; ring_i.rd_data = '0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wr_data = '0;
    rsp_ready = 1'b0; ring_i = '0;
    #2;
    check("rst_ring_o", ring_o, '0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp", {rsp_valid, rsp_status, rsp_rd_data}, '0);
    check("rst_stats", {txn, err, tmo, stl}, '0);
    step(2);
    rst_n = 1'b1;
    check("rdy_before_edge", cmd_ready, 1'b0);
    step();
    check("rdy_after_edge", cmd_ready, 1'b1);
    // read 0x100, ack after 3 WAIT cycles
    issue(1'b0, 16'h0100, 32'h0);
    check("rd_issue_strb", {ring_o.wr_strb, ring_o.rd_strb, cmd_ready}, 3'b010);
    check("rd_issue_addr", ring_o.addr, 16'h0100);
    step();
    check("rd_wait_strb", {ring_o.wr_strb, ring_o.rd_strb}, 2'b00);
    step(2);
    check("rd_wait_norsp", rsp_valid, 1'b0);
    pulse_ack(1'b1, 1'b0, 32'hDEADBEEF);
    check("rd_rsp", {rsp_valid, rsp_status, rsp_rd_data}, {1'b1, 2'd0, 32'hDEADBEEF});
    check("rd_txn", txn, 16'd1);
    handshake();
    check("rd_done", {rsp_valid, cmd_ready}, 2'b01);
    // write with err_ack
    issue(1'b1, 16'h0020, 32'h12345678);
    check("wr_issue_strb", {ring_o.wr_strb, ring_o.rd_strb}, 2'b10);
    check("wr_issue_bus", {ring_o.addr, ring_o.wr_data}, {16'h0020, 32'h12345678});
    step();
    check("wr_wait_bus", {ring_o.wr_strb, ring_o.addr, ring_o.wr_data}, {1'b0, 16'h0020, 32'h12345678});
    check("ring_o_const", {ring_o.rd_data, ring_o.ack, ring_o.err_ack}, '0);
    pulse_ack(1'b1, 1'b1, 32'h55555555);
    check("wr_err_rsp", {rsp_valid, rsp_status, rsp_rd_data}, {1'b1, 2'd1, 32'h0});
    check("wr_err_stats", {txn, err}, {16'd2, 16'd1});
    handshake();
    // read timeout
    issue(1'b0, 16'h0040, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("tmo_wait%0d", i), rsp_valid, 1'b0);
    end
    step();
    check("tmo_rsp", {rsp_valid, rsp_status, rsp_rd_data}, {1'b1, 2'd2, 32'h0});
    check("tmo_stats", {txn, tmo}, {16'd3, 16'd1});
    pulse_ack(1'b1, 1'b0, 32'h11111111);
    check("stale_in_resp", {txn, err, tmo, stl}, {16'd3, 16'd1, 16'd1, 16'd1});
    check("stale_rsp_kept", {rsp_valid, rsp_status, rsp_rd_data}, {1'b1, 2'd2, 32'h0});
    handshake();
    // ack in the timeout-expiry cycle wins
    issue(1'b0, 16'h0044, 32'h0);
    step(8);
    check("exp_norsp", rsp_valid, 1'b0);
    pulse_ack(1'b1, 1'b0, 32'hA5A50001);
    check("exp_rsp", {rsp_valid, rsp_status, rsp_rd_data}, {1'b1, 2'd0, 32'hA5A50001});
    check("exp_stats", {txn, tmo}, {16'd4, 16'd1});
    // backpressure on response with a pending command
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0055; cmd_wr_data = 32'hCAFE0000;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("bp%0d", i), {cmd_ready, rsp_valid, rsp_status, rsp_rd_data}, {2'b01, 2'd0, 32'hA5A50001});
    end
    handshake();
    check("bp_after_hs", {cmd_ready, rsp_valid}, 2'b10);
    step();
    cmd_valid = 1'b0;
    check("bp_next_issue", {ring_o.wr_strb, ring_o.addr, ring_o.wr_data}, {1'b1, 16'h0055, 32'hCAFE0000});
    step();
    pulse_ack(1'b1, 1'b0, 32'hFFFFFFFF);
    check("wr_ok_rsp", {rsp_valid, rsp_status, rsp_rd_data}, {1'b1, 2'd0, 32'h0});
    check("wr_ok_txn", txn, 16'd5);
    handshake();
    // reset during WAIT, then late ack
    issue(1'b0, 16'h0080, 32'h0);
    step();
    rst_n = 1'b0;
    #1;
    check("async_rst", {cmd_ready, rsp_valid, ring_o.rd_strb, ring_o.addr, txn, err, tmo, stl}, '0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_rdy", cmd_ready, 1'b1);
    pulse_ack(1'b1, 1'b0, 32'h12121212);
    step();
    check("post_rst_norsp", rsp_valid, 1'b0);
    check("post_rst_stats", {txn, err, tmo, stl}, {16'd0, 16'd0, 16'd0, 16'd1});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
